// File: rtl/cfa_pkg.sv
// rtl/cfa_pkg.sv - shared site, pattern, state and tag definitions for the CFA scheduler
package cfa_pkg;

    // CFA site codes, expressed on the RGGB base grid
    localparam logic [1:0] SITE_R  = 2'd0;
    localparam logic [1:0] SITE_GR = 2'd1;
    localparam logic [1:0] SITE_GB = 2'd2;
    localparam logic [1:0] SITE_B  = 2'd3;

    // Bayer pattern codes; each is the XOR offset applied to {row[0], col[0]}
    localparam logic [1:0] PAT_RGGB = 2'd0;
    localparam logic [1:0] PAT_GRBG = 2'd1;
    localparam logic [1:0] PAT_GBRG = 2'd2;
    localparam logic [1:0] PAT_BGGR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // Tag layout {site[1:0], sof, eol, eof}; the valid flag rides above it in the delay line
    localparam int TAG_W    = 5;
    localparam int TAG_EOF  = 0;
    localparam int TAG_EOL  = 1;
    localparam int TAG_SOF  = 2;
    localparam int TAG_SITE = 3;

    function automatic logic [1:0] site_decode(input logic row0, input logic col0,
                                               input logic [1:0] pat);
        return {row0 ^ pat[1], col0 ^ pat[0]};
    endfunction

endpackage

// File: rtl/cfa_tag_delay.sv
// rtl/cfa_tag_delay.sv - fixed-depth tag shift register with synchronous reset
module cfa_tag_delay #(
    parameter int W     = 6,
    parameter int DEPTH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data_out
);

    logic [W-1:0] stage [DEPTH];

    // Shift one stage per cycle, never stalls; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/cfa_site_scheduler.sv
// rtl/cfa_site_scheduler.sv - Bayer site tracking, interpolator select and aligned tag delay
module cfa_site_scheduler
    import cfa_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int CNT_BW    = 12,
    parameter int PIPE_LAT  = 3,
    parameter int BAYER_PAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic [1:0]        site,
    output logic              sel_rb_on_g,
    output logic              sel_on_rb,
    output logic [CNT_BW-1:0] col,
    output logic [CNT_BW-1:0] row,
    output logic              out_valid,
    output logic [1:0]        out_site,
    output logic              out_sof,
    output logic              out_eol,
    output logic              frame_done,
    output logic              sof_err
);

    localparam logic [1:0]        PAT      = 2'(BAYER_PAT);
    localparam logic [CNT_BW-1:0] LAST_COL = CNT_BW'(IMG_W - 1);
    localparam logic [CNT_BW-1:0] LAST_ROW = CNT_BW'(IMG_H - 1);

    state_t            state;
    logic              restart;
    logic              accept;
    logic [CNT_BW-1:0] eff_row;
    logic [CNT_BW-1:0] eff_col;
    logic              at_eol;
    logic              at_eof;
    logic              is_green;
    logic [TAG_W:0]    tag_in;
    logic [TAG_W:0]    tag_out;

    // Decode the current pixel; an sof restarts the grid at (0,0) for this very pixel
    always_comb begin
        restart  = in_valid && in_sof;
        accept   = in_valid && (state == ST_ACTIVE || in_sof);
        eff_row  = restart ? '0 : row;
        eff_col  = restart ? '0 : col;
        site     = site_decode(eff_row[0], eff_col[0], PAT);
        is_green = (site == SITE_GR) || (site == SITE_GB);
        at_eol   = (eff_col == LAST_COL);
        at_eof   = at_eol && (eff_row == LAST_ROW);
        tag_in   = accept ? {1'b1, site, restart, at_eol, at_eof} : '0;
    end

    assign sel_rb_on_g = accept && is_green;
    assign sel_on_rb   = accept && !is_green;

    // Frame FSM with raster counters; FLUSH holds until the eof tag leaves the delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            row     <= '0;
            col     <= '0;
            sof_err <= 1'b0;
        end else begin
            sof_err <= restart && (state == ST_ACTIVE) && (row != '0 || col != '0);
            if (accept) begin
                if (at_eof) begin
                    row   <= '0;
                    col   <= '0;
                    state <= ST_FLUSH;
                end else if (at_eol) begin
                    row   <= eff_row + 1'b1;
                    col   <= '0;
                    state <= ST_ACTIVE;
                end else begin
                    row   <= eff_row;
                    col   <= eff_col + 1'b1;
                    state <= ST_ACTIVE;
                end
            end else if (state == ST_FLUSH && frame_done) begin
                state <= ST_IDLE;
            end
        end
    end

    cfa_tag_delay #(
        .W     (TAG_W + 1),
        .DEPTH (PIPE_LAT)
    ) u_tag_delay (
        .clk      (clk),
        .rst      (rst),
        .data_in  (tag_in),
        .data_out (tag_out)
    );

    // Tail stage is zero for bubbles, so each field can drive its output directly
    always_comb begin
        out_valid  = tag_out[TAG_W];
        out_site   = tag_out[TAG_SITE +: 2];
        out_sof    = tag_out[TAG_SOF];
        out_eol    = tag_out[TAG_EOL];
        frame_done = tag_out[TAG_W] && tag_out[TAG_EOF];
    end

endmodule
